// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-entry busy
// scoreboard. NRD combinational read ports with optional same-cycle write
// bypass, two writeback ports (port 1 wins on a shared address), a
// reserve/release scoreboard with a running busy count, and a flush that
// clears every busy bit without touching data.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  localparam int CW = AW + 1;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;
  logic inc;
  logic dec0;
  logic dec1;

  // A write or reserve aimed at the hardwired zero entry is treated as if it
  // never happened; nothing is accepted while reset is held, which also keeps
  // the bypass path from leaking data onto the read ports during reset.
  assign wr0_ok = rst_n && wr0_en && !(ZR && (wr0_addr == '0));
  assign wr1_ok = rst_n && wr1_en && !(ZR && (wr1_addr == '0));
  assign rsv_ok = rst_n && rsv_en && !(ZR && (rsv_addr == '0));

  // Data array: port 1 is applied after port 0 so it wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        regs[wr0_addr] <= wr0_data;
      end
      if (wr1_ok) begin
        regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // Next busy vector: flush beats reserve, reserve beats a write release.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr0_ok) begin
        busy_next[wr0_addr] = 1'b0;
      end
      if (wr1_ok) begin
        busy_next[wr1_addr] = 1'b0;
      end
      if (rsv_ok) begin
        busy_next[rsv_addr] = 1'b1;
      end
    end
    if (ZR) begin
      busy_next[0] = 1'b0;
    end
  end

  // Busy count delta: a reserve adds one only if the bit was clear; a write
  // subtracts one only if it really clears a set bit, a reserve to the same
  // entry cancels the release, and two writes to one entry count once.
  always_comb begin
    inc  = rsv_ok && !busy[rsv_addr];
    dec0 = wr0_ok && busy[wr0_addr] && !(rsv_ok && (rsv_addr == wr0_addr));
    dec1 = wr1_ok && busy[wr1_addr] && !(rsv_ok && (rsv_addr == wr1_addr))
           && !(wr0_ok && (wr0_addr == wr1_addr));
    if (flush) begin
      cnt_next = '0;
    end else begin
      cnt_next = busy_cnt + CW'(inc) - CW'(dec0) - CW'(dec1);
    end
  end

  // Scoreboard state and its running population count move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // Read ports: newest write data first (port 1, then port 0), then the array.
  // A bypassed write also hides the busy bit it is about to release.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit0;
    logic          hit1;

    assign addr = rd_addr[k*AW +: AW];
    assign hit1 = BP && wr1_ok && (wr1_addr == addr);
    assign hit0 = BP && wr0_ok && (wr0_addr == addr);
    assign rd_data[k*XLEN +: XLEN] = hit1 ? wr1_data : (hit0 ? wr0_data : regs[addr]);
    assign rd_busy[k] = busy[addr] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: exercises two builds of regfile_mp side by side.
//   dut_a: XLEN=32, NREGS=32, NRD=2, ZERO_REG=1, BYPASS=1
//   dut_b: XLEN=64, NREGS=16, NRD=4, ZERO_REG=1, BYPASS=0
// Directed scenarios plus random traffic compared to a behavioural model.
module tb_regfile_mp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr0_en;
  logic [4:0]  a_wr0_addr;
  logic [31:0] a_wr0_data;
  logic        a_wr1_en;
  logic [4:0]  a_wr1_addr;
  logic [31:0] a_wr1_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;
  logic [5:0]  a_busy_cnt;

  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr0_en;
  logic [3:0]   b_wr0_addr;
  logic [63:0]  b_wr0_data;
  logic         b_wr1_en;
  logic [3:0]   b_wr1_addr;
  logic [63:0]  b_wr1_data;
  logic         b_rsv_en;
  logic [3:0]   b_rsv_addr;
  logic         b_flush;
  logic [4:0]   b_busy_cnt;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .flush(a_flush),
    .busy_cnt(a_busy_cnt)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .flush(b_flush),
    .busy_cnt(b_busy_cnt)
  );

  // Reference model state for both builds.
  logic [31:0] ma_regs [32];
  bit          ma_busy [32];
  logic [63:0] mb_regs [16];
  bit          mb_busy [16];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma_regs[i] = '0;
      ma_busy[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      mb_regs[i] = '0;
      mb_busy[i] = 1'b0;
    end
  endtask

  // Apply one clock edge's worth of the register-file rules to the model.
  task automatic model_edge();
    if (!rst_n) return;
    for (int i = 1; i < 32; i++) begin
      if (a_flush) ma_busy[i] = 1'b0;
      else if (a_rsv_en && int'(a_rsv_addr) == i) ma_busy[i] = 1'b1;
      else if ((a_wr0_en && int'(a_wr0_addr) == i) || (a_wr1_en && int'(a_wr1_addr) == i))
        ma_busy[i] = 1'b0;
    end
    if (a_wr0_en && a_wr0_addr != 5'd0) ma_regs[a_wr0_addr] = a_wr0_data;
    if (a_wr1_en && a_wr1_addr != 5'd0) ma_regs[a_wr1_addr] = a_wr1_data;
    for (int i = 1; i < 16; i++) begin
      if (b_flush) mb_busy[i] = 1'b0;
      else if (b_rsv_en && int'(b_rsv_addr) == i) mb_busy[i] = 1'b1;
      else if ((b_wr0_en && int'(b_wr0_addr) == i) || (b_wr1_en && int'(b_wr1_addr) == i))
        mb_busy[i] = 1'b0;
    end
    if (b_wr0_en && b_wr0_addr != 4'd0) mb_regs[b_wr0_addr] = b_wr0_data;
    if (b_wr1_en && b_wr1_addr != 4'd0) mb_regs[b_wr1_addr] = b_wr1_data;
  endtask

  function automatic logic [31:0] exp_a_data(int ad);
    if (ad == 0) return '0;
    if (a_wr1_en && int'(a_wr1_addr) == ad) return a_wr1_data;
    if (a_wr0_en && int'(a_wr0_addr) == ad) return a_wr0_data;
    return ma_regs[ad];
  endfunction

  function automatic logic exp_a_busy(int ad);
    if (ad == 0) return 1'b0;
    if ((a_wr1_en && int'(a_wr1_addr) == ad) || (a_wr0_en && int'(a_wr0_addr) == ad)) return 1'b0;
    return ma_busy[ad];
  endfunction

  function automatic logic [63:0] exp_b_data(int ad);
    if (ad == 0) return '0;
    return mb_regs[ad];
  endfunction

  function automatic int pop_a();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(ma_busy[i]);
    return n;
  endfunction

  function automatic int pop_b();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(mb_busy[i]);
    return n;
  endfunction

  task automatic idle();
    a_wr0_en = 0; a_wr0_addr = '0; a_wr0_data = '0;
    a_wr1_en = 0; a_wr1_addr = '0; a_wr1_data = '0;
    a_rsv_en = 0; a_rsv_addr = '0; a_flush = 0;
    b_wr0_en = 0; b_wr0_addr = '0; b_wr0_data = '0;
    b_wr1_en = 0; b_wr1_addr = '0; b_wr1_data = '0;
    b_rsv_en = 0; b_rsv_addr = '0; b_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int ad = 0; ad < 32; ad++) begin
      a_rd_addr = {5'(31 - ad), 5'(ad)};
      b_rd_addr = {4{4'(ad)}};
      #1;
      total++;
      if (a_rd_data !== 64'd0) begin
        bad++; $display("[TB] FAIL reset_a_data addr=%0d got=%h exp=0", ad, a_rd_data);
      end
      total++;
      if (a_rd_busy !== 2'b00) begin
        bad++; $display("[TB] FAIL reset_a_busy addr=%0d got=%b exp=00", ad, a_rd_busy);
      end
      total++;
      if (b_rd_data !== 256'd0 || b_rd_busy !== 4'b0000) begin
        bad++; $display("[TB] FAIL reset_b_read addr=%0d busy=%b exp data=0 busy=0000", ad, b_rd_busy);
      end
    end
    total++;
    if (a_busy_cnt !== 6'd0 || b_busy_cnt !== 5'd0) begin
      bad++; $display("[TB] FAIL reset_cnt got a=%0d b=%0d exp 0", a_busy_cnt, b_busy_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    a_wr0_en = 1; a_wr0_addr = 5'd5; a_wr0_data = 32'hDEADBEEF;
    a_rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL wr_bypass got=%h exp=deadbeef", a_rd_data[31:0]);
    end
    tick(); idle();
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL wr_array got=%h exp=deadbeef", a_rd_data[31:0]);
    end
    a_wr0_en = 1; a_wr0_addr = 5'd0; a_wr0_data = 32'h1234;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    total++;
    if (a_rd_data !== 64'd0) begin
      bad++; $display("[TB] FAIL r0_bypass got=%h exp=0", a_rd_data);
    end
    tick(); idle();
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'd0 || a_busy_cnt !== 6'd0) begin
      bad++; $display("[TB] FAIL r0_write got=%h cnt=%0d exp 0 cnt 0", a_rd_data[31:0], a_busy_cnt);
    end
  endtask

  task automatic test_dual_write();
    a_wr0_en = 1; a_wr0_addr = 5'd7; a_wr0_data = 32'hAAAA;
    a_wr1_en = 1; a_wr1_addr = 5'd7; a_wr1_data = 32'h5555;
    a_rd_addr = {5'd7, 5'd7};
    #1;
    total++;
    if (a_rd_data !== {32'h5555, 32'h5555}) begin
      bad++; $display("[TB] FAIL dual_bypass got=%h exp=5555 on both", a_rd_data);
    end
    tick(); idle();
    @(negedge clk);
    total++;
    if (a_rd_data[63:32] !== 32'h5555) begin
      bad++; $display("[TB] FAIL dual_array got=%h exp=5555", a_rd_data[63:32]);
    end
  endtask

  task automatic test_reserve();
    a_rsv_en = 1; a_rsv_addr = 5'd3; tick();
    a_rsv_addr = 5'd4; tick();
    a_rsv_addr = 5'd9; tick();
    idle();
    total++;
    if (a_busy_cnt !== 6'd3) begin
      bad++; $display("[TB] FAIL rsv_cnt got=%0d exp=3", a_busy_cnt);
    end
    a_rd_addr = {5'd9, 5'd3};
    @(negedge clk);
    total++;
    if (a_rd_busy !== 2'b11) begin
      bad++; $display("[TB] FAIL rsv_busy got=%b exp=11", a_rd_busy);
    end
    a_wr1_en = 1; a_wr1_addr = 5'd3; a_wr1_data = 32'h33;
    #1;
    total++;
    if (a_rd_busy !== 2'b10 || a_rd_data[31:0] !== 32'h33) begin
      bad++; $display("[TB] FAIL release_bypass got busy=%b data=%h exp busy=10 data=33", a_rd_busy, a_rd_data[31:0]);
    end
    tick(); idle();
    total++;
    if (a_busy_cnt !== 6'd2) begin
      bad++; $display("[TB] FAIL release_cnt got=%0d exp=2", a_busy_cnt);
    end
  endtask

  task automatic test_rsv_write_conflict();
    a_rsv_en = 1; a_rsv_addr = 5'd6;
    a_wr0_en = 1; a_wr0_addr = 5'd6; a_wr0_data = 32'h66;
    a_rd_addr = {5'd4, 5'd6};
    #1;
    total++;
    if (a_rd_busy !== 2'b10) begin
      bad++; $display("[TB] FAIL conflict_pre got=%b exp=10", a_rd_busy);
    end
    tick(); idle();
    total++;
    if (a_busy_cnt !== 6'd3) begin
      bad++; $display("[TB] FAIL conflict_cnt got=%0d exp=3", a_busy_cnt);
    end
    @(negedge clk);
    total++;
    if (a_rd_busy !== 2'b11 || a_rd_data[31:0] !== 32'h66) begin
      bad++; $display("[TB] FAIL conflict_post got busy=%b data=%h exp busy=11 data=66", a_rd_busy, a_rd_data[31:0]);
    end
    a_flush = 1; a_rsv_en = 1; a_rsv_addr = 5'd8;
    a_rd_addr = {5'd8, 5'd6};
    tick(); idle();
    total++;
    if (a_busy_cnt !== 6'd0) begin
      bad++; $display("[TB] FAIL flush_cnt got=%0d exp=0", a_busy_cnt);
    end
    #1;
    total++;
    if (a_rd_busy !== 2'b00 || a_rd_data[31:0] !== 32'h66) begin
      bad++; $display("[TB] FAIL flush_state got busy=%b data=%h exp busy=00 data=66", a_rd_busy, a_rd_data[31:0]);
    end
  endtask

  task automatic test_reset_midstream();
    a_rsv_en = 1; a_rsv_addr = 5'd4;
    b_rsv_en = 1; b_rsv_addr = 4'd3;
    tick(); idle();
    a_wr0_en = 1; a_wr0_addr = 5'd5; a_wr0_data = 32'h99;
    tick(); idle();
    total++;
    if (a_busy_cnt !== 6'd1 || b_busy_cnt !== 5'd1) begin
      bad++; $display("[TB] FAIL mid_pre_cnt got a=%0d b=%0d exp 1 and 1", a_busy_cnt, b_busy_cnt);
    end
    a_rsv_en = 1; a_rsv_addr = 5'd10;
    a_wr0_en = 1; a_wr0_addr = 5'd11; a_wr0_data = 32'h1;
    a_rd_addr = {5'd5, 5'd4};
    b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
    @(negedge clk);
    total++;
    if (a_rd_busy !== 2'b01 || a_rd_data[63:32] !== 32'h99) begin
      bad++; $display("[TB] FAIL mid_pre_read got busy=%b data=%h exp busy=01 data=99", a_rd_busy, a_rd_data[63:32]);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 || a_busy_cnt !== 6'd0) begin
      bad++; $display("[TB] FAIL mid_reset_a got data=%h busy=%b cnt=%0d exp all 0", a_rd_data, a_rd_busy, a_busy_cnt);
    end
    total++;
    if (b_rd_busy !== 4'b0000 || b_busy_cnt !== 5'd0) begin
      bad++; $display("[TB] FAIL mid_reset_b got busy=%b cnt=%0d exp all 0", b_rd_busy, b_busy_cnt);
    end
    tick();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    a_rd_addr = {5'd11, 5'd10};
    #1;
    total++;
    if (a_rd_data[63:32] !== 32'd0 || a_rd_busy !== 2'b00 || a_busy_cnt !== 6'd0) begin
      bad++; $display("[TB] FAIL mid_discard got data=%h busy=%b cnt=%0d exp all 0", a_rd_data[63:32], a_rd_busy, a_busy_cnt);
    end
  endtask

  task automatic test_no_bypass();
    b_wr0_en = 1; b_wr0_addr = 4'd2; b_wr0_data = 64'h11;
    tick(); idle();
    b_rsv_en = 1; b_rsv_addr = 4'd2;
    tick(); idle();
    b_wr0_en = 1; b_wr0_addr = 4'd2; b_wr0_data = 64'h77;
    b_rd_addr = {4'd0, 4'd2, 4'd0, 4'd0};
    @(negedge clk);
    total++;
    if (b_rd_data[128 +: 64] !== 64'h11 || b_rd_busy[2] !== 1'b1) begin
      bad++; $display("[TB] FAIL nobyp_same got data=%h busy=%b exp data=11 busy=1", b_rd_data[128 +: 64], b_rd_busy[2]);
    end
    tick(); idle();
    @(negedge clk);
    total++;
    if (b_rd_data[128 +: 64] !== 64'h77 || b_rd_busy[2] !== 1'b0 || b_busy_cnt !== 5'd0) begin
      bad++; $display("[TB] FAIL nobyp_next got data=%h busy=%b cnt=%0d exp data=77 busy=0 cnt=0", b_rd_data[128 +: 64], b_rd_busy[2], b_busy_cnt);
    end
    b_wr0_en = 1; b_wr0_addr = 4'd5; b_wr0_data = 64'hA;
    b_wr1_en = 1; b_wr1_addr = 4'd5; b_wr1_data = 64'hB;
    b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
    tick(); idle();
    total++;
    if (b_rd_data[63:0] !== 64'hB) begin
      bad++; $display("[TB] FAIL nobyp_prio got=%h exp=b", b_rd_data[63:0]);
    end
  endtask

  task automatic test_random_a(int n);
    for (int c = 0; c < n; c++) begin
      a_wr0_en   = ($urandom_range(0, 99) < 40);
      a_wr0_addr = 5'($urandom_range(0, 31));
      a_wr0_data = $urandom;
      a_wr1_en   = ($urandom_range(0, 99) < 40);
      a_wr1_addr = ($urandom_range(0, 3) == 0) ? a_wr0_addr : 5'($urandom_range(0, 31));
      a_wr1_data = $urandom;
      a_rsv_en   = ($urandom_range(0, 99) < 50);
      a_rsv_addr = ($urandom_range(0, 3) == 0) ? a_wr1_addr : 5'($urandom_range(0, 31));
      a_flush    = ($urandom_range(0, 99) < 3);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: a_rd_addr[k*5 +: 5] = a_wr0_addr;
          1: a_rd_addr[k*5 +: 5] = a_wr1_addr;
          2: a_rd_addr[k*5 +: 5] = a_rsv_addr;
          default: a_rd_addr[k*5 +: 5] = 5'($urandom_range(0, 31));
        endcase
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (a_rd_data[k*32 +: 32] !== exp_a_data(int'(a_rd_addr[k*5 +: 5]))) begin
          bad++; $display("[TB] FAIL rand_a_data cyc=%0d port=%0d got=%h exp=%h", c, k,
                          a_rd_data[k*32 +: 32], exp_a_data(int'(a_rd_addr[k*5 +: 5])));
        end
        total++;
        if (a_rd_busy[k] !== exp_a_busy(int'(a_rd_addr[k*5 +: 5]))) begin
          bad++; $display("[TB] FAIL rand_a_busy cyc=%0d port=%0d got=%b exp=%b", c, k,
                          a_rd_busy[k], exp_a_busy(int'(a_rd_addr[k*5 +: 5])));
        end
      end
      tick();
      total++;
      if (int'(a_busy_cnt) !== pop_a()) begin
        bad++; $display("[TB] FAIL rand_a_cnt cyc=%0d got=%0d exp=%0d", c, a_busy_cnt, pop_a());
      end
    end
    idle();
  endtask

  task automatic test_random_b(int n);
    for (int c = 0; c < n; c++) begin
      b_wr0_en   = ($urandom_range(0, 99) < 40);
      b_wr0_addr = 4'($urandom_range(0, 15));
      b_wr0_data = {$urandom, $urandom};
      b_wr1_en   = ($urandom_range(0, 99) < 40);
      b_wr1_addr = ($urandom_range(0, 3) == 0) ? b_wr0_addr : 4'($urandom_range(0, 15));
      b_wr1_data = {$urandom, $urandom};
      b_rsv_en   = ($urandom_range(0, 99) < 50);
      b_rsv_addr = ($urandom_range(0, 3) == 0) ? b_wr1_addr : 4'($urandom_range(0, 15));
      b_flush    = ($urandom_range(0, 99) < 3);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: b_rd_addr[k*4 +: 4] = b_wr0_addr;
          1: b_rd_addr[k*4 +: 4] = b_wr1_addr;
          2: b_rd_addr[k*4 +: 4] = b_rsv_addr;
          default: b_rd_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (b_rd_data[k*64 +: 64] !== exp_b_data(int'(b_rd_addr[k*4 +: 4]))) begin
          bad++; $display("[TB] FAIL rand_b_data cyc=%0d port=%0d got=%h exp=%h", c, k,
                          b_rd_data[k*64 +: 64], exp_b_data(int'(b_rd_addr[k*4 +: 4])));
        end
        total++;
        if (b_rd_busy[k] !== mb_busy[b_rd_addr[k*4 +: 4]]) begin
          bad++; $display("[TB] FAIL rand_b_busy cyc=%0d port=%0d got=%b exp=%b", c, k,
                          b_rd_busy[k], mb_busy[b_rd_addr[k*4 +: 4]]);
        end
      end
      tick();
      total++;
      if (int'(b_busy_cnt) !== pop_b()) begin
        bad++; $display("[TB] FAIL rand_b_cnt cyc=%0d got=%0d exp=%0d", c, b_busy_cnt, pop_b());
      end
    end
    idle();
  endtask

  // Scenario sequence; reset is held from time zero until test_reset releases it.
  initial begin
    idle();
    a_rd_addr = '0;
    b_rd_addr = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_dual_write();
    test_reserve();
    test_rsv_write_conflict();
    test_reset_midstream();
    test_no_bypass();
    test_random_a(400);
    test_random_b(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
